// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   NOP_INSTR     : canonical RV64 NOP (addi x0, x0, 0) used as the pipeline bubble
//   t_fetch_state : fetch FSM state encoding
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    MISS  = 1'b1
  } t_fetch_state;

endpackage

// File: rtl/preg_fetch.sv
// Fetch/decode pipeline register.
// Priority: flush -> bubble, stall -> hold, bubble -> bubble, otherwise load.
// Ports:
//   i_clk, i_arst           : clock, async active-high reset (resets to bubble)
//   i_stall                 : hold current contents
//   i_flush                 : force bubble (wins over stall)
//   i_bubble                : no valid instruction this cycle, load bubble
//   i_instr/i_pc/i_pc_plus4 : next contents
//   o_instruction/o_pc/o_pc_plus4 : registered contents to decode
module preg_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic                   i_bubble,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  input  logic [ADDR_WIDTH-1:0]  i_pc,
  input  logic [ADDR_WIDTH-1:0]  i_pc_plus4,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [ADDR_WIDTH-1:0]  o_pc_plus4
);

  localparam logic [INSTR_WIDTH-1:0] BUBBLE_INSTR = INSTR_WIDTH'(NOP_INSTR);

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      o_instruction <= BUBBLE_INSTR;
      o_pc          <= '0;
      o_pc_plus4    <= '0;
    end else if (i_flush || (!i_stall && i_bubble)) begin
      o_instruction <= BUBBLE_INSTR;
      o_pc          <= '0;
      o_pc_plus4    <= '0;
    end else if (!i_stall) begin
      o_instruction <= i_instr;
      o_pc          <= i_pc;
      o_pc_plus4    <= i_pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, I-cache request, miss FSM, redirect
// latch, and the fetch/decode pipeline register.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   FETCH | request at PC; a hit is consumed in the same cycle
//   MISS  | request at PC held until the cache returns; redirects are latched
//
// Ports:
//   i_clk, i_arst                 : clock, async active-high reset
//   i_stall_fetch, i_flush_dec    : hazard unit controls
//   i_pc_src, i_pc_target         : redirect from execute
//   o_imem_req, o_imem_addr       : I-cache request (always valid, address = PC)
//   i_imem_instr, i_imem_valid    : I-cache response
//   o_fetch_stall                 : miss in progress, to hazard unit
//   o_instruction, o_pc, o_pc_plus4 : F/D register contents
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 64,
  parameter int                    INSTR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic                   i_stall_fetch,
  input  logic                   i_flush_dec,
  input  logic                   i_pc_src,
  input  logic [ADDR_WIDTH-1:0]  i_pc_target,
  output logic                   o_imem_req,
  output logic [ADDR_WIDTH-1:0]  o_imem_addr,
  input  logic [INSTR_WIDTH-1:0] i_imem_instr,
  input  logic                   i_imem_valid,
  output logic                   o_fetch_stall,
  output logic [INSTR_WIDTH-1:0] o_instruction,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [ADDR_WIDTH-1:0]  o_pc_plus4
);

  t_fetch_state          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] redirect_addr;
  logic                  redirect_pending;
  logic                  drop;
  logic                  fd_bubble;

  assign pc_plus4      = pc + ADDR_WIDTH'(4);
  assign o_imem_req    = 1'b1;
  assign o_imem_addr   = pc;
  assign o_fetch_stall = (state == MISS) | ((state == FETCH) & !i_imem_valid);

  // A miss that completes with a redirect outstanding returns a wrong-path
  // instruction; it is discarded instead of being handed to decode.
  assign drop = (state == MISS) && i_imem_valid && (redirect_pending || i_pc_src);

  // The completing cycle of a miss still reports o_fetch_stall, but its
  // instruction is good and must be loaded, so the F/D bubble keys off the
  // response valid rather than the stall output.
  assign fd_bubble = !i_imem_valid || drop;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state            <= FETCH;
      pc               <= RESET_VECTOR;
      redirect_pending <= 1'b0;
      redirect_addr    <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (i_imem_valid) begin
            if (i_pc_src)            pc <= i_pc_target;
            else if (!i_stall_fetch) pc <= pc_plus4;
          end else begin
            state <= MISS;
            if (i_pc_src) begin
              redirect_pending <= 1'b1;
              redirect_addr    <= i_pc_target;
            end
          end
        end
        MISS: begin
          if (i_imem_valid) begin
            state <= FETCH;
            if (drop) begin
              pc               <= i_pc_src ? i_pc_target : redirect_addr;
              redirect_pending <= 1'b0;
            end else if (!i_stall_fetch) begin
              pc <= pc_plus4;
            end
          end else if (i_pc_src) begin
            redirect_pending <= 1'b1;
            redirect_addr    <= i_pc_target;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  preg_fetch #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_preg_fetch (
    .i_clk        (i_clk),
    .i_arst       (i_arst),
    .i_stall      (i_stall_fetch),
    .i_flush      (i_flush_dec),
    .i_bubble     (fd_bubble),
    .i_instr      (i_imem_instr),
    .i_pc         (pc),
    .i_pc_plus4   (pc_plus4),
    .o_instruction(o_instruction),
    .o_pc         (o_pc),
    .o_pc_plus4   (o_pc_plus4)
  );

endmodule
